ascon_state_reg: RTL and testbench
==================================

// Module: ascon_state_reg
// PURPOSE
// - Parametrised ASCON permutation-state register: NWORDS x W-bit words with per-word write mask.
// - Supports full/partial load and XOR-absorb of data into the state.
// - Adds a LIFO shadow stack of DEPTH snapshots, so the FSM can save the state and roll it back.
// - Sits between the ASCON control FSM and the permutation datapath; it replaces the plain enable flop.
// PARAMETERS
// - NWORDS  5   number of state words (5 = ASCON state)
// - W       64  bits per word
// - DEPTH   4   shadow-stack entries, >=1
// PORTS
// - clock_i   in   1              rising-edge clock
// - reset_i   in   1              synchronous, active-high reset
// - cmd_i     in   3              command: 0 NOP, 1 LOAD, 2 XOR, 3 SAVE, 4 RESTORE, 5 CLR_ERR, 6/7 NOP
// - mask_i    in   NWORDS         per-word select for LOAD/XOR; bit k -> word k
// - d_i       in   NWORDS x W     packed [NWORDS-1:0][W-1:0] data input
// - q_o       out  NWORDS x W     registered state
// - count_o   out  $clog2(DEPTH+1)  occupied stack entries
// - full_o    out  1              count_o == DEPTH
// - empty_o   out  1              count_o == 0
// - err_o     out  1              sticky overflow/underflow flag
// - busy_o    out  1              zeroize in progress (only with ASCON_STATE_ZEROIZE_EN; otherwise tied 0)
// BEHAVIOUR
// - Reset: q_o=0, count_o=0, err_o=0, busy_o=0; stack storage cleared to 0. Reset overrides every command.
// - Latency: every command samples inputs on edge N; q_o/flags show the result after edge N (1 cycle).
// - LOAD: for each k with mask_i[k]=1, q[k]<=d_i[k]; words with mask=0 hold. mask=0 -> no change.
// - XOR: for each k with mask_i[k]=1, q[k]<=q[k]^d_i[k]; words with mask=0 hold.
// - SAVE: stack[count]<=q (value before this edge); count+1; q unchanged.
//   - If full: push dropped, q and count unchanged, err_o<=1.
// - RESTORE: q<=stack[count-1]; count-1 (LIFO).
//   - If empty: q and count unchanged, err_o<=1.
// - CLR_ERR: err_o<=0; no other effect.
// - Codes 6/7 and NOP: q, count and err hold.
// - err_o is sticky; only reset or CLR_ERR clears it.
// - One command per cycle; mask_i and d_i are ignored for SAVE/RESTORE/CLR_ERR.
// - full_o/empty_o are combinational decodes of count_o; count_o never exceeds DEPTH and never wraps.
// CONFIGURATION
// - Macro ASCON_STATE_ZEROIZE_EN defined:
//   - Adds input zeroize_i (1 bit).
//   - A zeroize_i pulse on edge N: q<=0 at edge N; busy_o=1 from after edge N.
//   - A counter then clears one stack entry per cycle, entries 0..DEPTH-1, over edges N+1..N+DEPTH.
//   - After edge N+DEPTH: busy_o=0, count_o=0, err_o unchanged.
//   - While busy_o=1: cmd_i is ignored and zeroize_i re-pulses are ignored.
//   - Reset mid-zeroize: normal reset values, busy_o=0.
// - Macro undefined: no zeroize_i port; busy_o tied 0; no zeroize counter.
// TESTING (defaults NWORDS=5, W=64, DEPTH=4)
// - T1 reset: hold reset_i 2 cycles -> q_o all 0, count_o=0, empty_o=1, err_o=0.
// - T2 LOAD then XOR:
//   - LOAD mask=5'b11111, d[k]=64'h1000000000000000*(k+1) -> q_o==d.
//   - Then XOR mask=5'b00001, d[0]=64'hFFFF -> q[0]=64'h100000000000FFFF, words 1..4 unchanged.
// - T3 save/restore:
//   - SAVE with q[0]=64'hA; LOAD mask=1, d[0]=64'hB; SAVE; LOAD d[0]=64'hC.
//   - RESTORE -> q[0]=64'hB, count 1; RESTORE -> q[0]=64'hA, count 0, empty_o=1.
// - T4 overflow/underflow:
//   - 5 SAVEs -> count_o=4, full_o=1, err_o=1.
//   - CLR_ERR -> err_o=0.
//   - 5 RESTOREs -> 4th leaves count_o=0, 5th sets err_o=1 with q unchanged.
// - T5 reset mid-operation: count_o=3, assert reset_i with cmd_i=LOAD -> q_o=0, count_o=0, load not applied.
// - T6 (ZEROIZE_EN):
//   - Setup: count_o=2, q nonzero.
//   - Pulse zeroize_i -> q_o=0 next cycle, busy_o high exactly 4 cycles, LOADs during busy ignored.
//   - Then RESTORE -> err_o=1 (stack empty).

Source files
------------

// File: rtl/ascon_state_reg.sv
// ascon_state_reg: ASCON permutation-state register with a per-word write mask
// and a LIFO shadow stack of state snapshots.
//
// The control FSM issues one command per cycle. The register can load or
// XOR-absorb data into selected words, push the current state onto the stack,
// or pop a snapshot back into the state. Stack overflow and underflow set a
// sticky error flag.
//
// Optional feature (macro ASCON_STATE_ZEROIZE_EN):
//   Adds zeroize_i. A pulse clears the state immediately. It then wipes one
//   stack entry per cycle while busy_o is high. Commands are ignored during
//   the wipe. Without the macro, busy_o is tied low.
//
// Ports:
//   clock_i    rising-edge clock
//   reset_i    synchronous active-high reset; overrides every command
//   zeroize_i  zeroize request (only with ASCON_STATE_ZEROIZE_EN)
//   cmd_i      0 NOP, 1 LOAD, 2 XOR, 3 SAVE, 4 RESTORE, 5 CLR_ERR, 6/7 NOP
//   mask_i     per-word select for LOAD/XOR; bit k selects word k
//   d_i        data words for LOAD/XOR
//   q_o        registered state
//   count_o    occupied stack entries
//   full_o     count_o == DEPTH
//   empty_o    count_o == 0
//   err_o      sticky overflow/underflow flag
//   busy_o     zeroize in progress

module ascon_state_reg #(
  parameter int unsigned NWORDS = 5,
  parameter int unsigned W      = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
`ifdef ASCON_STATE_ZEROIZE_EN
  input  logic                          zeroize_i,
`endif
  input  logic [2:0]                    cmd_i,
  input  logic [NWORDS-1:0]             mask_i,
  input  logic [NWORDS-1:0][W-1:0]      d_i,
  output logic [NWORDS-1:0][W-1:0]      q_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          err_o,
  output logic                          busy_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  // Keep the index at least one bit wide so DEPTH=1 still elaborates.
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [NWORDS-1:0][W-1:0] state_t;

  typedef enum logic [2:0] {
    CmdNop     = 3'd0,
    CmdLoad    = 3'd1,
    CmdXor     = 3'd2,
    CmdSave    = 3'd3,
    CmdRestore = 3'd4,
    CmdClrErr  = 3'd5
  } cmd_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 q_q, q_d;
  state_t [DEPTH-1:0]     stack_q, stack_d;
  logic   [CntW-1:0]      cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                   full, empty;
  logic                   cmd_en;
  logic   [IdxW-1:0]      push_idx, pop_idx;
  cmd_e                   cmd;

`ifdef ASCON_STATE_ZEROIZE_EN
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  logic                   busy_q, busy_d;
  logic   [IdxW-1:0]      zcnt_q, zcnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign cmd      = cmd_e'(cmd_i);
  assign full     = (cnt_q == CntW'(DEPTH));
  assign empty    = (cnt_q == '0);
  // Truncation is safe: push_idx is only used when not full, pop_idx only
  // when not empty, so both stay within 0..DEPTH-1.
  assign push_idx = IdxW'(cnt_q);
  assign pop_idx  = IdxW'(cnt_q - CntW'(1));

`ifdef ASCON_STATE_ZEROIZE_EN
  // A zeroize request or an ongoing wipe swallows the command.
  assign cmd_en = ~busy_q & ~zeroize_i;
`else
  assign cmd_en = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    q_d     = q_q;
    stack_d = stack_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef ASCON_STATE_ZEROIZE_EN
    busy_d  = busy_q;
    zcnt_d  = zcnt_q;
`endif

    if (cmd_en) begin
      case (cmd)
        CmdLoad: begin
          for (int unsigned k = 0; k < NWORDS; k++) begin
            if (mask_i[k]) q_d[k] = d_i[k];
          end
        end
        CmdXor: begin
          for (int unsigned k = 0; k < NWORDS; k++) begin
            if (mask_i[k]) q_d[k] = q_q[k] ^ d_i[k];
          end
        end
        CmdSave: begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            stack_d[push_idx] = q_q;
            cnt_d             = cnt_q + CntW'(1);
          end
        end
        CmdRestore: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            q_d   = stack_q[pop_idx];
            cnt_d = cnt_q - CntW'(1);
          end
        end
        CmdClrErr: begin
          err_d = 1'b0;
        end
        default: begin
          // NOP and codes 6/7 hold everything.
        end
      endcase
    end

`ifdef ASCON_STATE_ZEROIZE_EN
    if (busy_q) begin
      // One entry per cycle. Count drops to zero with the last wipe, so the
      // stack reads as occupied until every entry is actually cleared.
      stack_d[zcnt_q] = '0;
      if (zcnt_q == LastIdx) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        zcnt_d = '0;
      end else begin
        zcnt_d = zcnt_q + IdxW'(1);
      end
    end else if (zeroize_i) begin
      q_d    = '0;
      busy_d = 1'b1;
      zcnt_d = '0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      q_q     <= '0;
      stack_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef ASCON_STATE_ZEROIZE_EN
      busy_q  <= 1'b0;
      zcnt_q  <= '0;
`endif
    end else begin
      q_q     <= q_d;
      stack_q <= stack_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef ASCON_STATE_ZEROIZE_EN
      busy_q  <= busy_d;
      zcnt_q  <= zcnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign q_o     = q_q;
  assign count_o = cnt_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign err_o   = err_q;
`ifdef ASCON_STATE_ZEROIZE_EN
  assign busy_o  = busy_q;
`else
  assign busy_o  = 1'b0;
`endif

  // The occupancy counter saturates at both ends and never wraps.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      assert (cnt_q <= CntW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_ascon_state_reg.sv
// Testbench for ascon_state_reg: directed scenarios followed by randomized
// commands. Every issued cycle pushes the reference model's expected outputs
// into a queue. A monitor pops one entry after each clock edge and compares.

module tb_ascon_state_reg;

  localparam int unsigned NW    = 5;
  localparam int unsigned W     = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] C_NOP = 3'd0, C_LOAD = 3'd1, C_XOR = 3'd2, C_SAVE = 3'd3;
  localparam logic [2:0] C_REST = 3'd4, C_CLR = 3'd5;

  typedef logic [NW-1:0][W-1:0] state_t;

  typedef struct {
    state_t q;
    int     cnt;
    bit     err;
    bit     busy;
  } exp_t;

  logic             clock_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             zeroize_i = 1'b0;
  logic [2:0]       cmd_i = '0;
  logic [NW-1:0]    mask_i = '0;
  state_t           d_i = '0;
  state_t           q_o;
  logic [CW-1:0]    count_o;
  logic             full_o, empty_o, err_o, busy_o;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];

  // Reference model: plain state, stack as a queue of snapshots.
  state_t m_q;
  state_t m_stack[$];
  bit     m_err;
  bit     m_busy;
  int     m_bcnt;

  always #5 clock_i = ~clock_i;

  ascon_state_reg #(
    .NWORDS(NW),
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
`ifdef ASCON_STATE_ZEROIZE_EN
    .zeroize_i(zeroize_i),
`endif
    .cmd_i    (cmd_i),
    .mask_i   (mask_i),
    .d_i      (d_i),
    .q_o      (q_o),
    .count_o  (count_o),
    .full_o   (full_o),
    .empty_o  (empty_o),
    .err_o    (err_o),
    .busy_o   (busy_o)
  );

  task automatic check(input string name, input logic [NW*W-1:0] act,
                       input logic [NW*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic state_t rand_state();
    state_t r;
    for (int k = 0; k < NW; k++) r[k] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic model_step(input bit rst, input logic [2:0] cmd, input logic [NW-1:0] mask,
                            input state_t d, input bit zero);
    if (rst) begin
      m_q = '0;
      m_stack.delete();
      m_err = 1'b0;
      m_busy = 1'b0;
      m_bcnt = 0;
    end else if (m_busy) begin
      m_bcnt++;
      if (m_bcnt == DEPTH) begin
        m_busy = 1'b0;
        m_stack.delete();
      end
    end else if (zero) begin
      m_q = '0;
      m_busy = 1'b1;
      m_bcnt = 0;
    end else begin
      case (cmd)
        C_LOAD: for (int k = 0; k < NW; k++) if (mask[k]) m_q[k] = d[k];
        C_XOR:  for (int k = 0; k < NW; k++) if (mask[k]) m_q[k] = m_q[k] ^ d[k];
        C_SAVE: if (m_stack.size() == DEPTH) m_err = 1'b1; else m_stack.push_back(m_q);
        C_REST: if (m_stack.size() == 0) m_err = 1'b1; else m_q = m_stack.pop_back();
        C_CLR:  m_err = 1'b0;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of stimulus and record what the DUT must show after it.
  task automatic issue(input bit rst, input logic [2:0] cmd, input logic [NW-1:0] mask,
                       input state_t d, input bit zero);
    exp_t e;
    bit   z;
`ifdef ASCON_STATE_ZEROIZE_EN
    z = zero;
`else
    z = 1'b0;
`endif
    @(negedge clock_i);
    reset_i   = rst;
    cmd_i     = cmd;
    mask_i    = mask;
    d_i       = d;
    zeroize_i = z;
    model_step(rst, cmd, mask, d, z);
    e.q    = m_q;
    e.cnt  = m_stack.size();
    e.err  = m_err;
    e.busy = m_busy;
    exp_q.push_back(e);
  endtask

  task automatic op(input logic [2:0] cmd);
    issue(1'b0, cmd, '0, rand_state(), 1'b0);
  endtask

  task automatic settle();
    @(posedge clock_i);
    #2;
  endtask

  // Monitor: every cycle the DUT presents a result; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q", q_o, e.q);
        check("count", NW*W'(count_o), NW*W'(e.cnt));
        check("full", NW*W'(full_o), NW*W'(e.cnt == DEPTH));
        check("empty", NW*W'(empty_o), NW*W'(e.cnt == 0));
        check("err", NW*W'(err_o), NW*W'(e.err));
        check("busy", NW*W'(busy_o), NW*W'(e.busy));
      end
    end
  end

  initial begin
    state_t d;
    logic [2:0] c;
    bit rst, zero;

    // T1: reset held for two cycles.
    issue(1'b1, C_NOP, '0, '0, 1'b0);
    issue(1'b1, C_NOP, '0, '0, 1'b0);

    // T2: full load then single-word XOR.
    for (int k = 0; k < NW; k++) d[k] = 64'(k + 1) << 60;
    issue(1'b0, C_LOAD, 5'b11111, d, 1'b0);
    d = rand_state();
    d[0] = 64'hFFFF;
    issue(1'b0, C_XOR, 5'b00001, d, 1'b0);
    settle();
    check("t2_word0", NW*W'(q_o[0]), NW*W'(64'h100000000000FFFF));
    check("t2_word4", NW*W'(q_o[4]), NW*W'(64'h5000000000000000));

    // T3: nested save/restore.
    d = rand_state();
    d[0] = 64'hA;
    issue(1'b0, C_LOAD, 5'b00001, d, 1'b0);
    op(C_SAVE);
    d[0] = 64'hB;
    issue(1'b0, C_LOAD, 5'b00001, d, 1'b0);
    op(C_SAVE);
    d[0] = 64'hC;
    issue(1'b0, C_LOAD, 5'b00001, d, 1'b0);
    op(C_REST);
    settle();
    check("t3_first_pop", NW*W'(q_o[0]), NW*W'(64'hB));
    check("t3_count1", NW*W'(count_o), NW*W'(1));
    op(C_REST);
    settle();
    check("t3_second_pop", NW*W'(q_o[0]), NW*W'(64'hA));
    check("t3_empty", NW*W'(empty_o), NW*W'(1));

    // T4: overflow, clear, underflow.
    for (int i = 0; i < 5; i++) op(C_SAVE);
    settle();
    check("t4_full", NW*W'({full_o, err_o, count_o}), NW*W'({1'b1, 1'b1, CW'(4)}));
    op(C_CLR);
    for (int i = 0; i < 5; i++) op(C_REST);

    // T5: reset wins over a simultaneous load.
    op(C_CLR);
    for (int i = 0; i < 3; i++) op(C_SAVE);
    issue(1'b1, C_LOAD, 5'b11111, rand_state(), 1'b0);
    settle();
    check("t5_reset_q", q_o, '0);

`ifdef ASCON_STATE_ZEROIZE_EN
    // T6: zeroize wipes state and stack; commands during the wipe are ignored.
    issue(1'b0, C_LOAD, 5'b11111, rand_state(), 1'b0);
    op(C_SAVE);
    op(C_SAVE);
    issue(1'b0, C_NOP, '0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) issue(1'b0, C_LOAD, 5'b11111, rand_state(), 1'b1);
    op(C_REST);
`endif

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      zero = ($urandom_range(0, 31) == 0);
      c    = 3'($urandom_range(0, 7));
      d    = rand_state();
      issue(rst, c, NW'($urandom), d, zero);
    end

    op(C_NOP);
    @(negedge clock_i);
    @(negedge clock_i);
    check("queue_drained", NW*W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
